// File: rtl/pwm_slice.sv
// rtl/pwm_slice.sv - PWM slice with sawtooth/triangle counter and two compare channels
// Shadowed TOP/compare/polarity take effect only at period boundaries while enabled.
module pwm_slice #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_en,
  input  logic             en,
  input  logic             phase_correct,
  input  logic [CNT_W-1:0] TOP,
  input  logic [CNT_W-1:0] CC_A,
  input  logic [CNT_W-1:0] CC_B,
  input  logic             invert_a,
  input  logic             invert_b,
  output logic [CNT_W-1:0] ctr,
  output logic             pwm_a,
  output logic             pwm_b,
  output logic             wrap
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  dir_t             dir, dir_nxt;
  logic [CNT_W-1:0] ctr_nxt;
  logic [CNT_W-1:0] top_q, cca_q, ccb_q;
  logic             inva_q, invb_q;
  logic             tick, wrap_evt;

  assign tick = en & pulse_en;

  always_comb begin
    ctr_nxt  = ctr;
    dir_nxt  = dir;
    wrap_evt = 1'b0;
    if (tick) begin
      if (!phase_correct) begin
        dir_nxt = UP;
        if (ctr >= top_q) begin
          ctr_nxt  = '0;
          wrap_evt = 1'b1;
        end else begin
          ctr_nxt = ctr + 1'b1;
        end
      end else if (top_q == '0 && ctr == '0) begin
        // Degenerate triangle: parked at zero, every tick closes a period.
        dir_nxt  = UP;
        ctr_nxt  = '0;
        wrap_evt = 1'b1;
      end else if (dir == UP) begin
        if (ctr >= top_q) begin
          dir_nxt = DOWN;
          ctr_nxt = (top_q == '0) ? '0 : top_q - 1'b1;
        end else begin
          ctr_nxt = ctr + 1'b1;
        end
      end else begin
        if (ctr == '0) begin
          dir_nxt  = UP;
          ctr_nxt  = CNT_W'(1);
          wrap_evt = 1'b1;
        end else begin
          ctr_nxt = ctr - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr    <= '0;
      dir    <= UP;
      wrap   <= 1'b0;
      top_q  <= '0;
      cca_q  <= '0;
      ccb_q  <= '0;
      inva_q <= 1'b0;
      invb_q <= 1'b0;
    end else begin
      ctr  <= ctr_nxt;
      dir  <= dir_nxt;
      wrap <= wrap_evt;
      // Disabled slices track inputs continuously; enabled ones only at wrap.
      if (!en || wrap_evt) begin
        top_q  <= TOP;
        cca_q  <= CC_A;
        ccb_q  <= CC_B;
        inva_q <= invert_a;
        invb_q <= invert_b;
      end
    end
  end

  assign pwm_a = (ctr < cca_q) ^ inva_q;
  assign pwm_b = (ctr < ccb_q) ^ invb_q;

endmodule
